// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: decoder FSM states, pixel geometry and the
// nanosecond timing targets both the receiver and the LED transmitter derive cycle counts from.
package ws2812_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } ws_state_t;

    localparam int PIXEL_BITS  = 24;
    localparam int HIGH_CNT_W  = 13;
    localparam int PIX_CNT_W   = 7;
    localparam int PIX_IDX_W   = 6;

    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_NUM_PIXELS  = 64;
    localparam int T0_MIN_NS       = 200;
    localparam int T_SPLIT_NS      = 600;
    localparam int T_HIGH_MAX_NS   = 1200;
    localparam int RESET_NS        = 50_000;

    // 64-bit intermediate so the 50 us latch time at high clock rates cannot overflow.
    function automatic int ns_to_cycles(input int clk_hz, input int ns);
        longint prod;
        prod = longint'(clk_hz) * longint'(ns);
        return int'(prod / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/ws2812_rx_sync2.sv
// Two-flop synchronizer bringing the asynchronous data line into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 one-wire stream decoder: measures high times to recover bits, assembles
// 24-bit GRB pixels and reports frame latches on a long low period.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int T0_MIN       = ns_to_cycles(CLK_HZ, T0_MIN_NS),
    parameter int T_SPLIT      = ns_to_cycles(CLK_HZ, T_SPLIT_NS),
    parameter int T_HIGH_MAX   = ns_to_cycles(CLK_HZ, T_HIGH_MAX_NS),
    parameter int RESET_CYCLES = ns_to_cycles(CLK_HZ, RESET_NS),
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    output logic [PIXEL_BITS-1:0]   pixel_data,
    output logic                    pixel_valid,
    output logic [PIX_IDX_W-1:0]    pixel_idx,
    output logic                    frame_done,
    output logic [PIX_CNT_W-1:0]    frame_pixels,
    output logic                    err
);

    localparam int LOW_W = $clog2(RESET_CYCLES + 1);

    logic din_s;
    logic din_q;

    ws_state_t state_reg, state_next;

    logic [LOW_W-1:0]      low_cnt_reg;
    logic [HIGH_CNT_W-1:0] high_cnt_reg;
    logic [PIXEL_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt_reg;
    logic                  pix_pend_reg;
    logic [PIX_CNT_W-1:0]  pixel_cnt_reg;
    logic                  frame_err_reg;

    logic [PIXEL_BITS-1:0] pixel_data_reg;
    logic                  pixel_valid_reg;
    logic [PIX_IDX_W-1:0]  pixel_idx_reg;
    logic                  frame_done_reg;
    logic [PIX_CNT_W-1:0]  frame_pixels_reg;
    logic                  err_reg;

    logic rise;
    logic low_full;
    logic sync_done;
    logic start_high;
    logic long_err;
    logic glitch;
    logic shift_en;
    logic bit_val;
    logic latch;
    logic drop;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q     <= 1'b0;
            state_reg <= S_SYNC;
        end else begin
            din_q     <= din_s;
            state_reg <= state_next;
        end
    end

    assign rise     = din_s & ~din_q;
    assign low_full = (low_cnt_reg == LOW_W'(RESET_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_SYNC: if (!din_s && low_full) state_next = S_IDLE;
            S_IDLE: if (rise) state_next = S_HIGH;
            S_HIGH: begin
                if (din_s) begin
                    if (high_cnt_reg > HIGH_CNT_W'(T_HIGH_MAX)) state_next = S_SYNC;
                end else if (high_cnt_reg < HIGH_CNT_W'(T0_MIN)) begin
                    state_next = S_SYNC;
                end else begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                // A rise on the latch cycle still starts the next frame's first bit.
                if (rise)          state_next = S_HIGH;
                else if (low_full) state_next = S_IDLE;
            end
            default: state_next = S_SYNC;
        endcase
    end

    always_comb begin
        sync_done  = (state_reg == S_SYNC) && !din_s && low_full;
        start_high = ((state_reg == S_IDLE) || (state_reg == S_LOW)) && rise;
        long_err   = (state_reg == S_HIGH) && din_s && (high_cnt_reg > HIGH_CNT_W'(T_HIGH_MAX));
        glitch     = (state_reg == S_HIGH) && !din_s && (high_cnt_reg < HIGH_CNT_W'(T0_MIN));
        shift_en   = (state_reg == S_HIGH) && !din_s && !glitch;
        bit_val    = (high_cnt_reg >= HIGH_CNT_W'(T_SPLIT));
        latch      = (state_reg == S_LOW) && low_full;
        drop       = glitch || long_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_cnt_reg      <= '0;
            high_cnt_reg     <= '0;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            pix_pend_reg     <= 1'b0;
            pixel_cnt_reg    <= '0;
            frame_err_reg    <= 1'b0;
            pixel_data_reg   <= '0;
            pixel_valid_reg  <= 1'b0;
            pixel_idx_reg    <= '0;
            frame_done_reg   <= 1'b0;
            frame_pixels_reg <= '0;
            err_reg          <= 1'b0;
        end else begin
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;

            if (state_reg == S_SYNC)
                low_cnt_reg <= (din_s || sync_done) ? '0 : low_cnt_reg + LOW_W'(1);
            else if (state_reg == S_LOW)
                low_cnt_reg <= latch ? '0 : low_cnt_reg + LOW_W'(1);
            else
                low_cnt_reg <= '0;

            if (start_high)
                high_cnt_reg <= '0;
            else if ((state_reg == S_HIGH) && din_s && (high_cnt_reg != '1))
                high_cnt_reg <= high_cnt_reg + HIGH_CNT_W'(1);

            if (drop) begin
                // The frame is abandoned; decoding restarts after a fresh sync low.
                shift_reg     <= '0;
                bit_cnt_reg   <= '0;
                pix_pend_reg  <= 1'b0;
                pixel_cnt_reg <= '0;
                err_reg       <= 1'b1;
            end else begin
                if (shift_en) begin
                    shift_reg    <= {shift_reg[PIXEL_BITS-2:0], bit_val};
                    bit_cnt_reg  <= bit_cnt_reg + 5'd1;
                    pix_pend_reg <= (bit_cnt_reg == 5'(PIXEL_BITS - 1));
                end

                if (pix_pend_reg) begin
                    pix_pend_reg <= 1'b0;
                    bit_cnt_reg  <= '0;
                    if (pixel_cnt_reg == PIX_CNT_W'(NUM_PIXELS)) begin
                        err_reg       <= 1'b1;
                        frame_err_reg <= 1'b1;
                    end else begin
                        pixel_data_reg  <= shift_reg;
                        pixel_valid_reg <= 1'b1;
                        pixel_idx_reg   <= pixel_cnt_reg[PIX_IDX_W-1:0];
                        pixel_cnt_reg   <= pixel_cnt_reg + PIX_CNT_W'(1);
                    end
                end

                if (latch) begin
                    frame_done_reg   <= 1'b1;
                    frame_pixels_reg <= pixel_cnt_reg;
                    pixel_cnt_reg    <= '0;
                    bit_cnt_reg      <= '0;
                    shift_reg        <= '0;
                    err_reg          <= frame_err_reg || (bit_cnt_reg != '0);
                    frame_err_reg    <= 1'b0;
                end

                if (sync_done) begin
                    frame_err_reg <= 1'b0;
                    pixel_cnt_reg <= '0;
                    bit_cnt_reg   <= '0;
                end
            end
        end
    end

    assign pixel_data   = pixel_data_reg;
    assign pixel_valid  = pixel_valid_reg;
    assign pixel_idx    = pixel_idx_reg;
    assign frame_done   = frame_done_reg;
    assign frame_pixels = frame_pixels_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx with timing scaled down 10x so full frames stay short.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int RC = 500;
    localparam int NP = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [5:0]  pixel_idx;
    logic        frame_done;
    logic [6:0]  frame_pixels;
    logic        err;

    always #5 clk = ~clk;

    ws2812_rx #(
        .CLK_HZ       (10_000_000),
        .T0_MIN       (2),
        .T_SPLIT      (6),
        .T_HIGH_MAX   (12),
        .RESET_CYCLES (RC),
        .NUM_PIXELS   (NP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_idx    (pixel_idx),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .err          (err)
    );

    typedef struct packed { logic [23:0] data; logic [5:0] idx; } pix_t;
    typedef struct packed { logic [6:0] n; logic e; } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes an output.
    initial begin
        pix_t p;
        frm_t f;
        forever begin
            @(negedge clk);
            if (pixel_valid) begin
                if (pix_q.size() == 0) begin
                    chk("pixel_unexpected_valid", 32'(pixel_valid), 32'd0);
                end else begin
                    p = pix_q.pop_front();
                    chk("pixel_data", 32'(pixel_data), 32'(p.data));
                    chk("pixel_idx", 32'(pixel_idx), 32'(p.idx));
                    $display("pixel idx=%0d data=%06h", pixel_idx, pixel_data);
                end
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    chk("frame_unexpected_done", 32'(frame_done), 32'd0);
                end else begin
                    f = frm_q.pop_front();
                    chk("frame_pixels", 32'(frame_pixels), 32'(f.n));
                    chk("frame_err", 32'(err), 32'(f.e));
                    $display("frame pixels=%0d err=%0b", frame_pixels, err);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: run still active at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin hold(1'b1, 8); hold(1'b0, 5); end
        else   begin hold(1'b1, 4); hold(1'b0, 9); end
    endtask

    task automatic send_bits(input logic [23:0] p, input int nbits);
        for (int b = 23; b > 23 - nbits; b--) send_bit(p[b]);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_bits(p, 24);
    endtask

    task automatic exp_pixel(input logic [23:0] d, input int idx);
        pix_q.push_back({d, 6'(idx)});
    endtask

    task automatic exp_frame(input int n, input logic e);
        frm_q.push_back({7'(n), e});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pixel_data"}, 32'(pixel_data), 32'd0);
        chk({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({tag, "_pixel_idx"}, 32'(pixel_idx), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    function automatic logic [23:0] pat(input int i);
        logic [7:0] g, r, b;
        g = 8'(i * 7 + 1);
        r = 8'(255 - i);
        b = 8'(i) ^ 8'hA5;
        return {g, r, b};
    endfunction

    initial begin
        int lat;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Single pixel 0xFF0000 with latency measurement on the final bit
        hold(1'b0, RC + 10);
        exp_pixel(24'hFF0000, 0);
        send_bits(24'hFF0000, 23);
        hold(1'b1, 4);
        din = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pixel_valid) begin lat = k; break; end
        end
        // din drops half a cycle before its first sampling edge, hence 3 cycles + 1 negedge.
        chk("pixel_latency", 32'(lat), 32'd4);
        hold(1'b0, 5);
        exp_frame(1, 1'b0);
        hold(1'b0, RC + 10);

        // Full 64-pixel frame
        for (int i = 0; i < NP; i++) begin
            exp_pixel(pat(i), i);
            send_pixel(pat(i));
        end
        exp_frame(NP, 1'b0);
        hold(1'b0, RC + 10);
        chk("err_after_full_frame", 32'(err), 32'd0);

        // Glitch mid-pixel: error, no decode until resync, next clean frame clears err
        send_bits(24'hA5A5A5, 5);
        hold(1'b1, 1);
        hold(1'b0, 5);
        chk("err_after_glitch", 32'(err), 32'd1);
        send_pixel(24'h123456);
        hold(1'b0, RC + 10);
        chk("err_held_through_resync", 32'(err), 32'd1);
        exp_pixel(pat(100), 0);
        send_pixel(pat(100));
        exp_pixel(pat(101), 1);
        send_pixel(pat(101));
        exp_frame(2, 1'b0);
        hold(1'b0, RC + 10);
        chk("err_cleared_by_clean_frame", 32'(err), 32'd0);

        // 65 pixels: the last one is refused
        for (int i = 0; i < NP + 1; i++) begin
            if (i < NP) exp_pixel(pat(200 + i), i);
            send_pixel(pat(200 + i));
        end
        hold(1'b0, 4);
        chk("err_after_overflow", 32'(err), 32'd1);
        exp_frame(NP, 1'b1);
        hold(1'b0, RC + 10);

        // 12 bits then latch: partial pixel
        send_bits(24'hFFF000, 12);
        exp_frame(0, 1'b1);
        hold(1'b0, RC + 10);
        chk("err_after_partial", 32'(err), 32'd1);

        exp_pixel(pat(300), 0);
        send_pixel(pat(300));
        exp_frame(1, 1'b0);
        hold(1'b0, RC + 10);
        chk("err_after_clean_single", 32'(err), 32'd0);

        // Line stuck high
        hold(1'b1, 200);
        hold(1'b0, 3);
        chk("err_after_long_high", 32'(err), 32'd1);
        chk("state_after_long_high", 32'(dut.state_reg), 32'(S_SYNC));
        hold(1'b0, RC + 10);

        // Reset mid-pixel
        send_bits(pat(400), 10);
        hold(1'b1, 2);
        rst = 1'b0;
        hold(1'b0, 3);
        chk_all_zero("midreset");
        chk("state_in_reset", 32'(dut.state_reg), 32'(S_SYNC));
        rst = 1'b1;
        send_pixel(pat(401));
        hold(1'b0, 20);
        hold(1'b0, RC + 10);
        exp_pixel(pat(402), 0);
        send_pixel(pat(402));
        exp_frame(1, 1'b0);
        hold(1'b0, RC + 10);

        chk("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
        chk("frame_queue_drained", 32'(frm_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
